zx_tape_player: RTL and testbench
=================================

Name: zx_tape_player

Overview:
- Tape transmitter that turns a downloaded .p image in the tape buffer into a real ZX81/ZX80 cassette waveform on the CPU's tape input (IN FE bit 7).
- Lets the unpatched ROM LOAD routine, plus any custom loader, read programs at original speed.
- Counterpart to the ROM-patch fast loader, which consumes tape data directly into RAM.
- Sits between the tape buffer RAM (1-cycle registered read) and the keyboard/IO read mux.

Parameters:
- PULSE_HI, 488, ce ticks tape_out is high per pulse (~150 us at 3.25 MHz).
- PULSE_LO, 488, ce ticks low between pulses within a bit.
- BIT_GAP, 4225, ce ticks of silence after each bit (~1300 us).
- LEADER, 3250000, ce ticks of silence before the first byte (~1 s).
- AW, 14, tape buffer address width.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  3.25 MHz clock-enable tick; all timing counters advance only on ce.
- start  in  1  1-cycle pulse: begin playback from address 0; ignored while busy.
- stop  in  1  abort playback; output returns low.
- length  in  AW  number of bytes in the image; latched on start.
- rd_addr  out  AW  tape buffer read address.
- rd_req  out  1  1-cycle read strobe.
- rd_data  in  8  buffer data, valid the cycle after rd_req.
- tape_out  out  1  tape level; 1 = pulse high.
- busy  out  1  playback in progress.
- done  out  1  1-cycle pulse when the last bit gap expires.

Behaviour:
- Reset values: tape_out=0, busy=0, done=0, rd_req=0, rd_addr=0. FSM returns to IDLE.
- Reset or stop mid-operation also takes effect on the next clk_sys edge.
- FSM states: IDLE, LEADER, FETCH, WAITD, PULSE_H, PULSE_L, GAP, FINISH.
- IDLE:
  - start & length!=0 -> latch length, rd_addr=0, busy=1, go to LEADER.
  - start & length==0 -> done pulses the next cycle; busy stays 0.
- LEADER: tape_out=0 for LEADER ce ticks, then FETCH.
- FETCH: assert rd_req for one clk_sys cycle, then WAITD.
- WAITD: capture rd_data into an 8-bit shift register on the next cycle; bit_idx=7. Go to PULSE_H.
- Bit encoding, MSB first: bit 0 = 4 pulses, bit 1 = 9 pulses.
  - Each pulse: PULSE_H (tape_out=1, PULSE_HI ticks), then PULSE_L (0, PULSE_LO ticks).
  - Pulse counter reloads per bit.
  - The last pulse's PULSE_L is replaced by GAP (0, BIT_GAP ticks).
- GAP end:
  - bit_idx!=0 -> shift the register, bit_idx-1, go to PULSE_H.
  - bit_idx==0 and rd_addr+1 < length -> increment rd_addr, go to FETCH.
  - Otherwise -> FINISH.
- FINISH: one cycle with done=1, busy=0, then IDLE. rd_addr holds the last address.
- Counters are wide enough for LEADER (22 bits). A load of N means the state lasts exactly N ce ticks. The transition happens on the ce at which the counter hits 1.
- Fetch latency: FETCH and WAITD never wait for ce. The byte is ready before the next ce edge, so there is no timing jitter.
- start while busy has no effect. stop and start in the same cycle: stop wins.
- length is not re-sampled mid-play.

Optional Feature:
- Macro ZX_TAPE_NAME_PREFIX_EN.
- Defined: .p images lack the program name, so a single name byte 8'hA6 is emitted before buffer byte 0. 8'hA6 is inverse "A", and bit 7 set terminates the name. LOAD "" therefore accepts it. The name byte uses the same encoding; FETCH for address 0 follows its gap.
- Undefined: the buffer is played verbatim (for images that already contain a name).

Decomposition:
- Package zx_tape_pkg:
  - state enum tape_state_t;
  - localparams PULSES_0=4, PULSES_1=9;
  - NAME_BYTE=8'hA6;
  - default timing constants.
- One sub-module, zx_tape_bit_shaper:
  - inputs: bit value, go, ce;
  - outputs: tape_out, bit_done;
  - owns the pulse and gap counters.
  - The top module keeps the byte/address FSM.

Test Plan:
- Byte order: LEADER=10, PULSE_HI=PULSE_LO=2, BIT_GAP=20; buffer {8'h80}, length=1, start. Expect 9 pulses, then 7x(4 pulses), each followed by 20 low ticks; done exactly once; busy low afterwards.
- Multi-byte fetch: length=3, buffer {00,FF,5A}. Expect rd_addr sequence 0,1,2; rd_req three times; pulse counts per byte 32, 72, 52.
- length=0 start: done one cycle later; tape_out stays 0; rd_req never asserted.
- Abort: stop mid-PULSE_H of byte 1. Expect tape_out=0 and busy=0 the next cycle; a later start replays from address 0.
- ce gating: ce held low for 1000 cycles mid-pulse. Expect tape_out frozen; remaining tick count is unchanged when ce resumes.
- Name prefix: with ZX_TAPE_NAME_PREFIX_EN, length=1, data 00. Expect 8'hA6 (pattern 9,4,9,4,4,9,9,4 pulses) before 8x4-pulse bits. Without the macro, only the 8x4 pulses.

Source files
------------

// File: rtl/zx_tape_pkg.sv
// Shared types and constants for the ZX81/ZX80 tape player: FSM state encoding,
// pulse counts per bit value, the synthetic name byte and default timing.
package zx_tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEADER,
        ST_FETCH,
        ST_WAITD,
        ST_PULSE_H,
        ST_PULSE_L,
        ST_GAP,
        ST_FINISH
    } tape_state_t;

    localparam logic [3:0] PULSES_0  = 4'd4;
    localparam logic [3:0] PULSES_1  = 4'd9;
    localparam logic [7:0] NAME_BYTE = 8'hA6;

    localparam int DEF_PULSE_HI = 488;
    localparam int DEF_PULSE_LO = 488;
    localparam int DEF_BIT_GAP  = 4225;
    localparam int DEF_LEADER   = 3250000;

    localparam int LEAD_W = 22;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/zx_tape_bit_shaper.sv
// Turns one bit into its cassette waveform: 4 or 9 high/low pulses, with the
// final low phase stretched into the inter-bit gap. Counters advance on ce only.
module zx_tape_bit_shaper
    import zx_tape_pkg::*;
#(
    parameter int PULSE_HI = DEF_PULSE_HI,
    parameter int PULSE_LO = DEF_PULSE_LO,
    parameter int BIT_GAP  = DEF_BIT_GAP
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_abort,
    input  logic i_ce,
    input  logic i_go,
    input  logic i_bit,
    output logic o_tape_out,
    output logic o_bit_done
);

    tape_state_t        r_phase;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_pulses;
    logic               r_tape;

    // Combinational so the byte FSM can react on the very ce that ends the gap.
    assign o_bit_done = (r_phase == ST_GAP) && i_ce && (r_cnt == CNT_W'(1));
    assign o_tape_out = r_tape;

    always_ff @(posedge clk_sys) begin
        if (reset || i_abort) begin
            r_phase  <= ST_IDLE;
            r_cnt    <= '0;
            r_pulses <= '0;
            r_tape   <= 1'b0;
        end else if (i_go) begin
            r_phase  <= ST_PULSE_H;
            r_cnt    <= CNT_W'(PULSE_HI);
            r_pulses <= i_bit ? PULSES_1 : PULSES_0;
            r_tape   <= 1'b1;
        end else if (i_ce) begin
            case (r_phase)
                ST_PULSE_H: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_tape   <= 1'b0;
                        r_pulses <= r_pulses - 4'd1;
                        if (r_pulses == 4'd1) begin
                            r_phase <= ST_GAP;
                            r_cnt   <= CNT_W'(BIT_GAP);
                        end else begin
                            r_phase <= ST_PULSE_L;
                            r_cnt   <= CNT_W'(PULSE_LO);
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_PULSE_L: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_phase <= ST_PULSE_H;
                        r_cnt   <= CNT_W'(PULSE_HI);
                        r_tape  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_phase <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/zx_tape_player.sv
// Plays a .p image from the tape buffer as a real ZX81 cassette signal.
// Define ZX_TAPE_NAME_PREFIX_EN to emit the name byte 8'hA6 ahead of the image.
module zx_tape_player
    import zx_tape_pkg::*;
#(
    parameter int PULSE_HI = DEF_PULSE_HI,
    parameter int PULSE_LO = DEF_PULSE_LO,
    parameter int BIT_GAP  = DEF_BIT_GAP,
    parameter int LEADER   = DEF_LEADER,
    parameter int AW       = 14
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] length,
    output logic [AW-1:0] rd_addr,
    output logic          rd_req,
    input  logic [7:0]    rd_data,
    output logic          tape_out,
    output logic          busy,
    output logic          done
);

`ifdef ZX_TAPE_NAME_PREFIX_EN
    localparam logic NAME_EN = 1'b1;
`else
    localparam logic NAME_EN = 1'b0;
`endif

    tape_state_t        r_state;
    logic [AW-1:0]      r_len;
    logic [AW-1:0]      r_addr;
    logic               r_rd_req;
    logic               r_busy;
    logic               r_done;
    logic               r_go;
    logic               r_name;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_idx;
    logic [LEAD_W-1:0]  r_lead_cnt;

    logic               w_tape_out;
    logic               w_bit_done;
    logic [AW:0]        w_addr_inc;

    assign w_addr_inc = {1'b0, r_addr} + (AW+1)'(1);

    assign rd_addr  = r_addr;
    assign rd_req   = r_rd_req;
    assign tape_out = w_tape_out;
    assign busy     = r_busy;
    assign done     = r_done;

    zx_tape_bit_shaper #(
        .PULSE_HI (PULSE_HI),
        .PULSE_LO (PULSE_LO),
        .BIT_GAP  (BIT_GAP)
    ) u_shaper (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .i_abort    (stop),
        .i_ce       (ce),
        .i_go       (r_go),
        .i_bit      (r_shift[7]),
        .o_tape_out (w_tape_out),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_addr     <= '0;
            r_rd_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_go       <= 1'b0;
            r_name     <= 1'b0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_lead_cnt <= '0;
        end else if (stop) begin
            r_state  <= ST_IDLE;
            r_rd_req <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_go     <= 1'b0;
        end else begin
            r_go     <= 1'b0;
            r_done   <= 1'b0;
            r_rd_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr <= '0;
                        if (length != '0) begin
                            r_len      <= length;
                            r_busy     <= 1'b1;
                            r_name     <= NAME_EN;
                            r_lead_cnt <= LEAD_W'(LEADER);
                            r_state    <= ST_LEADER;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_LEADER: begin
                    if (ce) begin
                        if (r_lead_cnt == LEAD_W'(1)) begin
                            if (r_name) begin
                                r_shift   <= NAME_BYTE;
                                r_bit_idx <= 3'd7;
                                r_go      <= 1'b1;
                                r_state   <= ST_PULSE_H;
                            end else begin
                                r_rd_req <= 1'b1;
                                r_state  <= ST_FETCH;
                            end
                        end else begin
                            r_lead_cnt <= r_lead_cnt - LEAD_W'(1);
                        end
                    end
                end
                // rd_req is high for the whole FETCH cycle; data arrives during WAITD.
                ST_FETCH: r_state <= ST_WAITD;
                ST_WAITD: begin
                    r_shift   <= rd_data;
                    r_bit_idx <= 3'd7;
                    r_go      <= 1'b1;
                    r_state   <= ST_PULSE_H;
                end
                ST_PULSE_H: begin
                    if (w_bit_done) begin
                        if (r_bit_idx != 3'd0) begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_idx <= r_bit_idx - 3'd1;
                            r_go      <= 1'b1;
                        end else if (r_name) begin
                            r_name   <= 1'b0;
                            r_rd_req <= 1'b1;
                            r_state  <= ST_FETCH;
                        end else if (w_addr_inc < {1'b0, r_len}) begin
                            r_addr   <= w_addr_inc[AW-1:0];
                            r_rd_req <= 1'b1;
                            r_state  <= ST_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zx_tape_player.sv
// Directed bench for zx_tape_player: counts pulses per bit from the tape waveform
// and compares against hand-derived patterns, fetch order and control pulses.
module tb_zx_tape_player;

    localparam int T_LEADER = 10;
    localparam int T_HI     = 2;
    localparam int T_LO     = 2;
    localparam int T_GAP    = 20;
    localparam int BUDGET   = 20000;
`ifdef ZX_TAPE_NAME_PREFIX_EN
    localparam int NAME_BITS = 8;
`else
    localparam int NAME_BITS = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ce      = 1'b0;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic [13:0] length  = '0;
    logic [13:0] rd_addr;
    logic        rd_req;
    logic [7:0]  rd_data = '0;
    logic        tape_out;
    logic        busy;
    logic        done;

    always #5 clk_sys = ~clk_sys;

    zx_tape_player #(
        .PULSE_HI (T_HI),
        .PULSE_LO (T_LO),
        .BIT_GAP  (T_GAP),
        .LEADER   (T_LEADER),
        .AW       (14)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
        .start    (start),
        .stop     (stop),
        .length   (length),
        .rd_addr  (rd_addr),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .tape_out (tape_out),
        .busy     (busy),
        .done     (done)
    );

    logic [7:0] mem [0:15];
    always @(posedge clk_sys) if (rd_req) rd_data <= mem[rd_addr[3:0]];

    // ce: one cycle in five, can be frozen by the bench
    int ce_div = 0;
    bit ce_en  = 1'b1;
    always @(posedge clk_sys) begin
        ce_div <= (ce_div == 4) ? 0 : ce_div + 1;
        ce     <= ce_en && (ce_div == 3);
    end

    // waveform monitor
    int bit_q[$];
    int addr_q[$];
    int exp_q[$];
    int pulses_in_bit, hi_run, lo_run, bad_runs, done_cnt, rdreq_cnt, done_lo_run;
    bit mon_first, prev_tape;
    int clr_req = 0;
    int clr_ack = 0;

    initial begin
        prev_tape = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (clr_req != clr_ack) begin
                clr_ack = clr_req;
                bit_q.delete();
                addr_q.delete();
                pulses_in_bit = 0; hi_run = 0; lo_run = 0; bad_runs = 0;
                done_cnt = 0; rdreq_cnt = 0; done_lo_run = -1; mon_first = 1'b1;
            end else begin
                if (tape_out === 1'b1 && !prev_tape) begin
                    if (!mon_first && lo_run != T_LO && lo_run != T_GAP) bad_runs++;
                    mon_first = 1'b0;
                    pulses_in_bit++;
                    lo_run = 0;
                end
                if (tape_out === 1'b0 && prev_tape) begin
                    if (hi_run != T_HI) bad_runs++;
                    hi_run = 0;
                end
                if (ce) begin
                    if (tape_out) hi_run++;
                    else begin
                        lo_run++;
                        if (lo_run == T_GAP && pulses_in_bit > 0) begin
                            bit_q.push_back(pulses_in_bit);
                            pulses_in_bit = 0;
                        end
                    end
                end
                if (done) begin done_cnt++; done_lo_run = lo_run; end
                if (rd_req) begin rdreq_cnt++; addr_q.push_back(int'(rd_addr)); end
            end
            prev_tape = tape_out;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic clear_mon();
        clr_req++;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic pulse_start(input logic [13:0] len);
        @(negedge clk_sys);
        length = len;
        start  = 1'b1;
        @(negedge clk_sys);
        start  = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk_sys);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i] ? 9 : 4);
    endtask

    task automatic push_name();
        exp_q.delete();
        if (NAME_BITS != 0) push_byte(8'hA6);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk_sys);
        reset = 1'b0;
        n_tests++; if (tape_out !== 1'b0) begin n_fail++; $display("FAIL reset_tape: got %b want 0", tape_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq: got %b want 0", rd_req); end
        n_tests++; if (rd_addr !== 14'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        $display("[TB] reset checked");
    endtask

    task automatic test_byte_order();
        bit ok;
        mem[0] = 8'h80;
        push_name();
        push_byte(8'h80);
        clear_mon();
        pulse_start(14'd1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL order_busy_start: got %b want 1", busy); end
        wait_done(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL order_timeout: done never seen in %0d cycles", BUDGET); end
        n_tests++; if (bit_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL order_nbits: got %0d want %0d", bit_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < bit_q.size(); i++) begin
            n_tests++;
            if (bit_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL order_bit%0d: got %0d pulses want %0d", i, bit_q[i], exp_q[i]); end
        end
        n_tests++; if (bad_runs !== 0) begin n_fail++; $display("FAIL order_runs: got %0d bad high/low runs want 0", bad_runs); end
        n_tests++; if (done_lo_run !== T_GAP) begin n_fail++; $display("FAIL order_last_gap: got %0d ticks want %0d", done_lo_run, T_GAP); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL order_done_cnt: got %0d want 1", done_cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL order_busy_end: got %b want 0", busy); end
        $display("[TB] byte order: %0d bits, done x%0d", bit_q.size(), done_cnt);
    endtask

    task automatic test_multi_byte();
        bit ok;
        int want_sum[3];
        want_sum[0] = 32; want_sum[1] = 72; want_sum[2] = 52;
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h5A;
        clear_mon();
        pulse_start(14'd3);
        repeat (300) @(negedge clk_sys);
        pulse_start(14'd5);  // ignored while busy
        wait_done(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL multi_timeout: done never seen in %0d cycles", BUDGET); end
        n_tests++; if (rdreq_cnt !== 3) begin n_fail++; $display("FAIL multi_rdreq: got %0d want 3", rdreq_cnt); end
        for (int k = 0; k < 3; k++) begin
            int sum;
            sum = 0;
            for (int b = 0; b < 8; b++)
                if (NAME_BITS + 8 * k + b < bit_q.size()) sum += bit_q[NAME_BITS + 8 * k + b];
            n_tests++;
            if (k >= addr_q.size() || addr_q[k] !== k) begin n_fail++; $display("FAIL multi_addr%0d: got %0d want %0d", k, (k < addr_q.size()) ? addr_q[k] : -1, k); end
            n_tests++;
            if (sum !== want_sum[k]) begin n_fail++; $display("FAIL multi_pulses%0d: got %0d want %0d", k, sum, want_sum[k]); end
        end
        n_tests++; if (rd_addr !== 14'd2) begin n_fail++; $display("FAIL multi_last_addr: got %0d want 2", rd_addr); end
        n_tests++; if (bad_runs !== 0) begin n_fail++; $display("FAIL multi_runs: got %0d bad runs want 0", bad_runs); end
        $display("[TB] multi byte: %0d fetches, %0d bits", rdreq_cnt, bit_q.size());
    endtask

    task automatic test_len_zero();
        clear_mon();
        pulse_start(14'd0);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
        @(negedge clk_sys);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b want 0", done); end
        repeat (30) @(negedge clk_sys);
        n_tests++; if (rdreq_cnt !== 0) begin n_fail++; $display("FAIL zero_rdreq: got %0d want 0", rdreq_cnt); end
        n_tests++; if (pulses_in_bit !== 0) begin n_fail++; $display("FAIL zero_tape: got %0d pulses want 0", pulses_in_bit); end
        $display("[TB] length zero: done x%0d", done_cnt);
    endtask

    task automatic test_abort();
        bit ok;
        bit hit;
        mem[0] = 8'h00; mem[1] = 8'hFF;
        clear_mon();
        pulse_start(14'd2);
        hit = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk_sys);
            if (rd_addr == 14'd1 && tape_out === 1'b1) begin hit = 1'b1; break; end
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL abort_reach: byte 1 pulse not seen in %0d cycles", BUDGET); end
        stop = 1'b1;
        @(negedge clk_sys);
        stop = 1'b0;
        n_tests++; if (tape_out !== 1'b0) begin n_fail++; $display("FAIL abort_tape: got %b want 0", tape_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (50) @(negedge clk_sys);
        n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
        // stop and start together: stop wins
        stop = 1'b1; start = 1'b1; length = 14'd1;
        @(negedge clk_sys);
        stop = 1'b0; start = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_stop_wins: got busy %b want 0", busy); end
        mem[0] = 8'hC3;
        push_name();
        push_byte(8'hC3);
        clear_mon();
        pulse_start(14'd1);
        n_tests++; if (rd_addr !== 14'd0) begin n_fail++; $display("FAIL abort_restart_addr: got %0d want 0", rd_addr); end
        wait_done(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_replay_timeout: done never seen in %0d cycles", BUDGET); end
        n_tests++; if (addr_q.size() !== 1 || addr_q[0] !== 0) begin n_fail++; $display("FAIL abort_replay_addr: got %0d fetches want 1 at address 0", addr_q.size()); end
        n_tests++; if (bit_q !== exp_q) begin n_fail++; $display("FAIL abort_replay_bits: got %0d bits want %0d bits of C3", bit_q.size(), exp_q.size()); end
        $display("[TB] abort and replay: %0d bits", bit_q.size());
    endtask

    task automatic test_ce_gating();
        bit ok;
        bit hit;
        int frozen_err;
        int h0;
        mem[0] = 8'h00;
        push_name();
        push_byte(8'h00);
        clear_mon();
        pulse_start(14'd1);
        hit = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk_sys);
            if (tape_out === 1'b1) begin hit = 1'b1; break; end
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL gate_reach: no pulse in %0d cycles", BUDGET); end
        ce_en = 1'b0;
        @(negedge clk_sys);
        h0 = hi_run;
        frozen_err = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if (tape_out !== 1'b1) frozen_err++;
        end
        n_tests++; if (frozen_err !== 0) begin n_fail++; $display("FAIL gate_frozen: got %0d cycles not high want 0", frozen_err); end
        n_tests++; if (hi_run !== h0) begin n_fail++; $display("FAIL gate_ticks: got %0d ticks want %0d", hi_run, h0); end
        ce_en = 1'b1;
        wait_done(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL gate_timeout: done never seen in %0d cycles", BUDGET); end
        n_tests++; if (bad_runs !== 0) begin n_fail++; $display("FAIL gate_runs: got %0d bad runs want 0", bad_runs); end
        n_tests++; if (bit_q !== exp_q) begin n_fail++; $display("FAIL gate_bits: got %0d bits want %0d", bit_q.size(), exp_q.size()); end
        $display("[TB] ce gating: frozen 1000 cycles, %0d bits", bit_q.size());
    endtask

    task automatic test_name_prefix();
        bit ok;
        mem[0] = 8'h00;
        exp_q.delete();
`ifdef ZX_TAPE_NAME_PREFIX_EN
        exp_q = '{9, 4, 9, 4, 4, 9, 9, 4};
`endif
        for (int i = 0; i < 8; i++) exp_q.push_back(4);
        clear_mon();
        pulse_start(14'd1);
        wait_done(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL name_timeout: done never seen in %0d cycles", BUDGET); end
        n_tests++; if (bit_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL name_nbits: got %0d want %0d", bit_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < bit_q.size(); i++) begin
            n_tests++;
            if (bit_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL name_bit%0d: got %0d pulses want %0d", i, bit_q[i], exp_q[i]); end
        end
        $display("[TB] name prefix: %0d bits", bit_q.size());
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_byte_order();
        test_multi_byte();
        test_len_zero();
        test_abort();
        test_ce_gating();
        test_name_prefix();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
